// File: rtl/trav_stack_ctrl.sv
// kd-tree traversal stack controller: per-ray short stacks, next-node select.
// Optional stats counters enabled with `define TRAV_STACK_STATS_EN.
module trav_stack_ctrl #(
  parameter int RAY_ID_W = 6,
  parameter int NODE_W   = 16,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RAY_ID_W-1:0] in_ray_id,
  input  logic                in_leaf,
  input  logic                in_hit,
  input  logic [NODE_W-1:0]   low_child,
  input  logic [NODE_W-1:0]   high_child,
  input  logic                only_low,
  input  logic                only_high,
  input  logic                lo_then_hi,
  input  logic                hi_then_lo,
  input  logic [31:0]         t_min,
  input  logic [31:0]         t_max,
  input  logic [31:0]         t_mid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RAY_ID_W-1:0] out_ray_id,
  output logic [NODE_W-1:0]   out_node,
  output logic [31:0]         out_t_min,
  output logic [31:0]         out_t_max,
  output logic                done_valid,
  output logic [RAY_ID_W-1:0] done_ray_id,
  output logic                done_hit,
  output logic                ovf_pulse
`ifdef TRAV_STACK_STATS_EN
  ,
  output logic [31:0]         push_cnt,
  output logic [31:0]         pop_cnt,
  output logic [31:0]         ovf_cnt,
  output logic [31:0]         retire_cnt
`endif
);

  localparam int NUM_RAYS = 2**RAY_ID_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int REC_W    = NODE_W + 64;
  localparam int ADDR_W   = RAY_ID_W + PTR_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {S_RUN, S_POP} state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0] top_q [NUM_RAYS];
  logic [PTR_W-1:0] top_d [NUM_RAYS];
  logic [PTR_W:0]   cnt_q [NUM_RAYS];
  logic [PTR_W:0]   cnt_d [NUM_RAYS];

  logic                out_valid_q, out_valid_d;
  logic [RAY_ID_W-1:0] out_ray_id_q, out_ray_id_d;
  logic [NODE_W-1:0]   out_node_q, out_node_d;
  logic [31:0]         out_t_min_q, out_t_min_d;
  logic [31:0]         out_t_max_q, out_t_max_d;
  logic                done_valid_q, done_valid_d;
  logic [RAY_ID_W-1:0] done_ray_id_q, done_ray_id_d;
  logic                done_hit_q, done_hit_d;
  logic                ovf_q, ovf_d;
  logic [RAY_ID_W-1:0] pop_ray_q, pop_ray_d;

  logic [REC_W-1:0]  mem [NUM_RAYS*DEPTH];
  logic [REC_W-1:0]  rd_data_q;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [REC_W-1:0]  wr_data;
  logic [PTR_W-1:0]  cur_top, nxt_top;
  logic [PTR_W:0]    cur_cnt;
  logic              accept;

  assign in_ready = (state_q == S_RUN) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign cur_top  = top_q[in_ray_id];
  assign cur_cnt  = cnt_q[in_ray_id];
  assign nxt_top  = cur_top + PTR_W'(1);

  always_comb begin
    state_d       = state_q;
    top_d         = top_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_ray_id_d  = out_ray_id_q;
    out_node_d    = out_node_q;
    out_t_min_d   = out_t_min_q;
    out_t_max_d   = out_t_max_q;
    done_valid_d  = 1'b0;
    done_ray_id_d = done_ray_id_q;
    done_hit_d    = done_hit_q;
    ovf_d         = 1'b0;
    pop_ray_d     = pop_ray_q;
    wr_en         = 1'b0;
    wr_addr       = {in_ray_id, nxt_top};
    wr_data       = '0;
    rd_en         = 1'b0;
    rd_addr       = {in_ray_id, cur_top};

    if (state_q == S_POP) begin
      // output register is known empty here: the pop op required it
      out_valid_d  = 1'b1;
      out_ray_id_d = pop_ray_q;
      {out_node_d, out_t_min_d, out_t_max_d} = rd_data_q;
      state_d      = S_RUN;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept && !in_leaf) begin
        out_valid_d  = 1'b1;
        out_ray_id_d = in_ray_id;
        out_t_min_d  = t_min;
        out_node_d   = low_child;
        out_t_max_d  = t_max;
        if (only_low) begin
          out_node_d = low_child;
        end else if (only_high) begin
          out_node_d = high_child;
        end else if (lo_then_hi) begin
          out_node_d  = low_child;
          out_t_max_d = t_mid;
          wr_en       = 1'b1;
          wr_data     = {high_child, t_mid, t_max};
        end else if (hi_then_lo) begin
          out_node_d  = high_child;
          out_t_max_d = t_mid;
          wr_en       = 1'b1;
          wr_data     = {low_child, t_mid, t_max};
        end
        if (wr_en) begin
          top_d[in_ray_id] = nxt_top;
          if (cur_cnt == FULL) ovf_d = 1'b1;
          else cnt_d[in_ray_id] = cur_cnt + 1'b1;
        end
      end else if (accept && in_hit) begin
        cnt_d[in_ray_id] = '0;
        done_valid_d     = 1'b1;
        done_ray_id_d    = in_ray_id;
        done_hit_d       = 1'b1;
      end else if (accept && cur_cnt == '0) begin
        done_valid_d  = 1'b1;
        done_ray_id_d = in_ray_id;
        done_hit_d    = 1'b0;
      end else if (accept) begin
        rd_en            = 1'b1;
        top_d[in_ray_id] = cur_top - PTR_W'(1);
        cnt_d[in_ray_id] = cur_cnt - 1'b1;
        pop_ray_d        = in_ray_id;
        state_d          = S_POP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      for (int i = 0; i < NUM_RAYS; i++) begin
        top_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_ray_id_q  <= '0;
      out_node_q    <= '0;
      out_t_min_q   <= '0;
      out_t_max_q   <= '0;
      done_valid_q  <= 1'b0;
      done_ray_id_q <= '0;
      done_hit_q    <= 1'b0;
      ovf_q         <= 1'b0;
      pop_ray_q     <= '0;
    end else begin
      state_q       <= state_d;
      top_q         <= top_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_ray_id_q  <= out_ray_id_d;
      out_node_q    <= out_node_d;
      out_t_min_q   <= out_t_min_d;
      out_t_max_q   <= out_t_max_d;
      done_valid_q  <= done_valid_d;
      done_ray_id_q <= done_ray_id_d;
      done_hit_q    <= done_hit_d;
      ovf_q         <= ovf_d;
      pop_ray_q     <= pop_ray_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && !in_leaf)
      assert ($onehot({only_low, only_high, lo_then_hi, hi_then_lo}))
      else $error("trav_stack_ctrl: split flags not one-hot");
  end

  assign out_valid   = out_valid_q;
  assign out_ray_id  = out_ray_id_q;
  assign out_node    = out_node_q;
  assign out_t_min   = out_t_min_q;
  assign out_t_max   = out_t_max_q;
  assign done_valid  = done_valid_q;
  assign done_ray_id = done_ray_id_q;
  assign done_hit    = done_hit_q;
  assign ovf_pulse   = ovf_q;

`ifdef TRAV_STACK_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] pop_cnt_q, pop_cnt_d;
  logic [31:0] ovf_cnt_q, ovf_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    push_cnt_d   = sat_inc(push_cnt_q, wr_en);
    pop_cnt_d    = sat_inc(pop_cnt_q, rd_en);
    ovf_cnt_d    = sat_inc(ovf_cnt_q, ovf_d);
    retire_cnt_d = sat_inc(retire_cnt_q, done_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_cnt_q   <= '0;
      pop_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign push_cnt   = push_cnt_q;
  assign pop_cnt    = pop_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule
